// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the byte FIFO and the stages downstream of it.
package axis_pkg;

   localparam int unsigned AXIS_WIDTH   = 8;
   localparam int unsigned AXIS_COUNT_W = 16;

   typedef enum logic [1:0] {PASS, LEN, CSUM} trailer_state_t;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream output register; refills whenever the slot is empty or draining.
module axis_out_reg
   import axis_pkg::*;
#(
   parameter int unsigned width = AXIS_WIDTH
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             load,
   input  logic [width-1:0] load_data,
   input  logic             load_last,
   input  logic             M_TReady,
   output logic [width-1:0] M_TData,
   output logic             M_TValid,
   output logic             M_TLast,
   output logic             slot_free
);

   assign slot_free = !M_TValid || M_TReady;

   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         M_TData  <= '0;
         M_TValid <= 1'b0;
         M_TLast  <= 1'b0;
      end else if (slot_free) begin
         M_TValid <= load;
         if (load) begin
            M_TData <= load_data;
            M_TLast <= load_last;
         end
      end
   end

endmodule

// File: rtl/axis_frame_trailer.sv
// Passes packet bytes through, then appends length and XOR checksum words; TLast rides on the checksum.
module axis_frame_trailer
   import axis_pkg::*;
#(
   parameter int unsigned width   = AXIS_WIDTH,
   parameter int unsigned count_w = AXIS_COUNT_W
) (
   input  logic               CLK,
   input  logic               Reset,
   input  logic [width-1:0]   S_TData,
   input  logic               S_TValid,
   input  logic               S_TLast,
   output logic               S_TReady,
   output logic [width-1:0]   M_TData,
   output logic               M_TValid,
   output logic               M_TLast,
   input  logic               M_TReady,
   output logic               Busy,
   output logic [count_w-1:0] FrameCount
);

   trailer_state_t   state, next_state;
   logic [width-1:0] len, csum;
   logic             slot_free, accept;
   logic             load, load_last;
   logic [width-1:0] load_data;

   axis_out_reg #(.width(width)) u_out_reg (
      .CLK       (CLK),
      .Reset     (Reset),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .M_TReady  (M_TReady),
      .M_TData   (M_TData),
      .M_TValid  (M_TValid),
      .M_TLast   (M_TLast),
      .slot_free (slot_free)
   );

   assign S_TReady = (state == PASS) && slot_free;
   assign accept   = S_TValid && S_TReady;
   assign Busy     = (state != PASS);

   always_ff @(posedge CLK) begin
      if (Reset) state <= PASS;
      else       state <= next_state;
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      load       = 1'b0;
      load_data  = S_TData;
      load_last  = 1'b0;
      case (state)
         PASS: begin
            if (accept) begin
               load = 1'b1;
               if (S_TLast) next_state = LEN;
            end
         end
         LEN: begin
            if (slot_free) begin
               load       = 1'b1;
               load_data  = len;
               next_state = CSUM;
            end
         end
         CSUM: begin
            if (slot_free) begin
               load       = 1'b1;
               load_data  = csum;
               load_last  = 1'b1;
               next_state = PASS;
            end
         end
         default: next_state = PASS;
      endcase
   end

   // Length wraps modulo 2^width by design; the checksum word clears both accumulators.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         len  <= '0;
         csum <= '0;
      end else if (accept) begin
         len  <= len + width'(1);
         csum <= csum ^ S_TData;
      end else if (state == CSUM && slot_free) begin
         len  <= '0;
         csum <= '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset)
         FrameCount <= '0;
      else if (M_TValid && M_TReady && M_TLast)
         FrameCount <= FrameCount + count_w'(1);
   end

endmodule
